// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: ON/GAP time-slicing over NDIG digits with a double-buffered load port.
// Optional leading-zero blanking when the ZERO_SUPPRESS_EN macro is defined.
module seg_scan_ctrl #(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned DWELL_CYC = 12000,
  parameter int unsigned GAP_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [5*NDIG-1:0]       ld_code,
  input  logic [NDIG-1:0]         ld_dp,
  output logic [4:0]              code,
  output logic                    dp,
  output logic [NDIG-1:0]         dig_sel,
  output logic [$clog2(NDIG)-1:0] scan_idx
);

  localparam int unsigned IW   = $clog2(NDIG);
  localparam int unsigned CMAX = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [5*NDIG-1:0]   act_code_q, act_code_d;
  logic [NDIG-1:0]     act_dp_q, act_dp_d;
  logic [4:0]          code_q, code_d;
  logic                dp_q, dp_d;
  logic [NDIG-1:0]     dig_sel_q, dig_sel_d;
  logic                ld_ready_q, ld_ready_d;
  logic                xfer;
`ifdef ZERO_SUPPRESS_EN
  logic [NDIG-1:0]     supp;
  logic                zrun;
`endif

  // Next state, active-register load and next registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    xfer       = ld_valid & ld_ready_q;
    act_code_d = xfer ? ld_code : act_code_q;
    act_dp_d   = xfer ? ld_dp : act_dp_q;
    code_d     = 5'h1F;
    dp_d       = 1'b0;
    dig_sel_d  = '1;

    case (state_q)
      S_IDLE: begin
        state_d = S_ON;
        cnt_d   = '0;
        idx_d   = '0;
      end
      S_ON: begin
        if (cnt_q == CW'(DWELL_CYC - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          state_d = S_ON;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end

`ifdef ZERO_SUPPRESS_EN
    // A digit is blank when it and every more-significant digit are zero with no dp
    zrun = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zrun    = zrun & (act_code_d[5*i +: 5] == 5'd0) & ~act_dp_d[i];
      supp[i] = zrun & (i != 0);
    end
`endif

    if (state_d == S_ON) begin
      for (int i = 0; i < NDIG; i++) begin
        if (IW'(i) == idx_d) begin
          dig_sel_d[i] = 1'b0;
          code_d       = act_code_d[5*i +: 5];
          dp_d         = act_dp_d[i];
`ifdef ZERO_SUPPRESS_EN
          if (supp[i]) code_d = 5'h1F;
`endif
        end
      end
    end

    ld_ready_d = (state_d != S_ON);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_code_q <= {NDIG{5'h1F}};
      act_dp_q   <= '0;
      code_q     <= 5'h1F;
      dp_q       <= 1'b0;
      dig_sel_q  <= '1;
      ld_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_code_q <= act_code_d;
      act_dp_q   <= act_dp_d;
      code_q     <= code_d;
      dp_q       <= dp_d;
      dig_sel_q  <= dig_sel_d;
      ld_ready_q <= ld_ready_d;
    end
  end

  assign code     = code_q;
  assign dp       = dp_q;
  assign dig_sel  = dig_sel_q;
  assign scan_idx = idx_q;
  assign ld_ready = ld_ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic against a time-slot reference model.
module tb_seg_scan_ctrl;

  localparam int NDIG   = 4;
  localparam int DWELL  = 4;
  localparam int GAPC   = 2;
  localparam int SLOT   = DWELL + GAPC;
  localparam int PERIOD = SLOT * NDIG;

  logic            clk = 1'b0;
  logic            reset, enable, ld_valid, ld_ready, dp;
  logic [5*NDIG-1:0] ld_code;
  logic [NDIG-1:0] ld_dp, dig_sel;
  logic [4:0]      code;
  logic [1:0]      scan_idx;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: running flag, time within the scan period, and the active digit table
  bit         m_run;
  int         m_t;
  logic [4:0] m_code [NDIG];
  logic       m_dpv  [NDIG];
  bit         m_xfer;

  seg_scan_ctrl #(.NDIG(NDIG), .DWELL_CYC(DWELL), .GAP_CYC(GAPC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_code(ld_code), .ld_dp(ld_dp), .code(code), .dp(dp), .dig_sel(dig_sel),
    .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_on();
    return m_run && ((m_t % SLOT) < DWELL);
  endfunction

  function automatic int m_digit();
    return m_run ? (m_t / SLOT) % NDIG : 0;
  endfunction

  task automatic model_step();
    m_xfer = 1'b0;
    if (reset) begin
      m_run = 1'b0;
      m_t   = 0;
      for (int i = 0; i < NDIG; i++) begin m_code[i] = 5'h1F; m_dpv[i] = 1'b0; end
    end else begin
      if (ld_valid && !m_on()) begin
        for (int i = 0; i < NDIG; i++) begin
          m_code[i] = ld_code[5*i +: 5];
          m_dpv[i]  = ld_dp[i];
        end
        m_xfer = 1'b1;
      end
      if (!enable)     m_run = 1'b0;
      else if (!m_run) begin m_run = 1'b1; m_t = 0; end
      else             m_t = (m_t + 1) % PERIOD;
    end
  endtask

  task automatic check_outputs();
    logic [NDIG-1:0] e_sel;
    logic [4:0]      e_code;
    logic            e_dp;
    int              d;
    bit              blank;
    e_sel  = '1;
    e_code = 5'h1F;
    e_dp   = 1'b0;
    d      = m_digit();
    if (m_on()) begin
      e_sel[d] = 1'b0;
      e_code   = m_code[d];
      e_dp     = m_dpv[d];
`ifdef ZERO_SUPPRESS_EN
      blank = (d != 0);
      for (int j = d; j < NDIG; j++) if (m_code[j] != 5'd0 || m_dpv[j]) blank = 1'b0;
      if (blank) e_code = 5'h1F;
`else
      blank = 1'b0;
`endif
    end
    check("dig_sel",  32'(dig_sel),  32'(e_sel));
    check("code",     32'(code),     32'(e_code));
    check("dp",       32'(dp),       32'(e_dp));
    check("scan_idx", 32'(scan_idx), 32'(d));
    check("ld_ready", 32'(ld_ready), 32'(!m_on()));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_on_digit(input int d);
    bit found = 1'b0;
    for (int i = 0; i < 4 * PERIOD && !found; i++) begin
      tick();
      if (m_on() && m_digit() == d) found = 1'b1;
    end
    check("wait_on_digit", 32'(found), 32'd1);
  endtask

  task automatic send_load(input logic [5*NDIG-1:0] c, input logic [NDIG-1:0] p);
    bit done = 1'b0;
    ld_code  = c;
    ld_dp    = p;
    ld_valid = 1'b1;
    for (int i = 0; i < 2 * PERIOD && !done; i++) begin
      tick();
      if (m_xfer) done = 1'b1;
    end
    ld_valid = 1'b0;
    check("load_done", 32'(done), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    ld_valid = 1'b0;
    ld_code  = '0;
    ld_dp    = '0;
    m_run    = 1'b0;
    m_t      = 0;
    for (int i = 0; i < NDIG; i++) begin m_code[i] = 5'h1F; m_dpv[i] = 1'b0; end

    run(2);
    reset = 1'b0;
    run(2);

    // Free-running scan over one full period and a bit
    enable = 1'b1;
    run(PERIOD + 2);

    // Load requested mid-dwell of digit 1 is held until the gap
    wait_on_digit(1);
    send_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000);
    run(PERIOD + 4);

    // Special code with decimal point on digit 1
    send_load({5'd3, 5'd2, 5'h11, 5'd0}, 4'b0010);
    run(PERIOD + 4);

    // Drop enable mid-dwell of digit 2, then restart
    wait_on_digit(2);
    tick();
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(PERIOD + 4);

    // Reset pulse during ON with a load pending; active table must read blank
    wait_on_digit(1);
    reset    = 1'b1;
    ld_valid = 1'b1;
    ld_code  = {5'd9, 5'd8, 5'd7, 5'd6};
    tick();
    reset    = 1'b0;
    ld_valid = 1'b0;
    run(PERIOD + 4);

    // Leading zeros, then all zeros
    send_load({5'd0, 5'd0, 5'd0, 5'd7}, 4'b0000);
    run(PERIOD + 4);
    send_load({5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000);
    run(PERIOD + 4);
    send_load({5'd0, 5'd0, 5'd5, 5'd0}, 4'b0100);
    run(PERIOD + 4);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      enable   = ($urandom_range(0, 99) < 96);
      reset    = ($urandom_range(0, 199) == 0);
      ld_valid = ($urandom_range(0, 99) < 20);
      for (int k = 0; k < NDIG; k++) begin
        ld_code[5*k +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 19));
        ld_dp[k]          = ($urandom_range(0, 9) == 0);
      end
      tick();
    end
    reset    = 1'b0;
    ld_valid = 1'b0;
    enable   = 1'b1;
    run(PERIOD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
